// File: rtl/instr_exec_if.sv
// rtl/instr_exec_if.sv - instruction register / control output bundle for instr_exec
interface instr_exec_if;
  logic [7:0] instruction;
  logic       instr_latch_en;
  logic [7:0] trigger_channel_mask;
  logic       acq_start;
  logic       acq_stop;
  logic       soft_rstn;
  logic [7:0] force_trig;
  logic       cal_pulse;
  logic       busy;
  logic       instr_done;
  logic       err_illegal;
  logic       err_busy;
  logic [7:0] status;

  modport master (
    output instruction, instr_latch_en, trigger_channel_mask,
    input  acq_start, acq_stop, soft_rstn, force_trig, cal_pulse,
    input  busy, instr_done, err_illegal, err_busy, status
  );

  modport slave (
    input  instruction, instr_latch_en, trigger_channel_mask,
    output acq_start, acq_stop, soft_rstn, force_trig, cal_pulse,
    output busy, instr_done, err_illegal, err_busy, status
  );
endinterface

// File: rtl/instr_exec.sv
// rtl/instr_exec.sv - SPI instruction executor; optional status byte via INSTR_EXEC_STATUS_EN
module instr_exec #(
  parameter int RST_CYCLES = 16,
  parameter int TRIG_WIDTH = 4,
  parameter int CAL_PERIOD = 8
) (
  input  logic         iclk,
  input  logic         rstn,
  instr_exec_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, DECODE, ACT, CAL_GAP, DONE} state_t;

  localparam logic [7:0] RST_LEN  = 8'(RST_CYCLES);
  localparam logic [7:0] TRIG_LEN = 8'(TRIG_WIDTH);
  localparam logic [7:0] CAL_LEN  = 8'(CAL_PERIOD);

  state_t     state;
  logic       s1, s2, s3;
  logic       fall;
  logic [7:0] op_q, mask_q, cnt;
  logic [4:0] pulses;
  logic       is_cal;

  // write strobe crosses from sclk; the end of the latch pulse marks a completed write
  assign fall   = s3 & ~s2;
  assign is_cal = (op_q[7:4] == 4'h1);
  assign bus.busy = (state != IDLE);

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.instr_latch_en;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      op_q            <= 8'h00;
      mask_q          <= 8'h00;
      cnt             <= 8'h00;
      pulses          <= 5'd0;
      bus.acq_start   <= 1'b0;
      bus.acq_stop    <= 1'b0;
      bus.soft_rstn   <= 1'b1;
      bus.force_trig  <= 8'h00;
      bus.cal_pulse   <= 1'b0;
      bus.instr_done  <= 1'b0;
      bus.err_illegal <= 1'b0;
      bus.err_busy    <= 1'b0;
    end else begin
      bus.acq_start  <= 1'b0;
      bus.acq_stop   <= 1'b0;
      bus.instr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            op_q   <= bus.instruction;
            mask_q <= bus.trigger_channel_mask;
            state  <= DECODE;
          end
        end
        DECODE: begin
          state <= ACT;
          case (op_q)
            8'h00: begin
              bus.err_illegal <= 1'b0;
              bus.err_busy    <= 1'b0;
              bus.instr_done  <= 1'b1;
              state           <= DONE;
            end
            8'h01: begin cnt <= 8'd1;     bus.acq_start  <= 1'b1;   end
            8'h02: begin cnt <= 8'd1;     bus.acq_stop   <= 1'b1;   end
            8'h03: begin cnt <= RST_LEN;  bus.soft_rstn  <= 1'b0;   end
            8'h04: begin cnt <= TRIG_LEN; bus.force_trig <= mask_q; end
            default: begin
              if (is_cal) begin
                cnt           <= CAL_LEN;
                pulses        <= {1'b0, op_q[3:0]} + 5'd1;
                bus.cal_pulse <= 1'b1;
              end else begin
                bus.err_illegal <= 1'b1;
                bus.instr_done  <= 1'b1;
                state           <= DONE;
              end
            end
          endcase
        end
        ACT: begin
          // a count of 0 is treated as expired so the counter can never wrap
          if (cnt <= 8'd1) begin
            bus.soft_rstn  <= 1'b1;
            bus.force_trig <= 8'h00;
            bus.cal_pulse  <= 1'b0;
            if (is_cal) begin
              cnt   <= CAL_LEN;
              state <= CAL_GAP;
            end else begin
              bus.instr_done <= 1'b1;
              state          <= DONE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CAL_GAP: begin
          if (cnt <= 8'd1) begin
            if (pulses <= 5'd1) begin
              bus.instr_done <= 1'b1;
              state          <= DONE;
            end else begin
              pulses        <= pulses - 5'd1;
              cnt           <= CAL_LEN;
              bus.cal_pulse <= 1'b1;
              state         <= ACT;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // writes landing outside IDLE (DONE included) are dropped
      if (fall && state != IDLE) bus.err_busy <= 1'b1;
    end
  end

`ifdef INSTR_EXEC_STATUS_EN
  logic [3:0] exec_cnt;

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) exec_cnt <= 4'd0;
    else if (state == DONE) exec_cnt <= exec_cnt + 4'd1;
  end

  assign bus.status = {bus.busy, bus.err_illegal, bus.err_busy, 1'b0, exec_cnt};
`else
  assign bus.status = 8'h00;
`endif
endmodule

// File: tb/tb_instr_exec.sv
// tb/tb_instr_exec.sv - directed self-checking bench for instr_exec
module tb_instr_exec;
  logic iclk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instr_exec_if bus ();

  instr_exec #(.RST_CYCLES(16), .TRIG_WIDTH(4), .CAL_PERIOD(8)) dut (
    .iclk (iclk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // latch_en high for 3 iclk periods; returns at the negedge where it falls
  task automatic write_instr(input logic [7:0] op, input logic [7:0] mask);
    @(negedge iclk);
    bus.instruction          = op;
    bus.trigger_channel_mask = mask;
    bus.instr_latch_en       = 1'b1;
    repeat (3) @(negedge iclk);
    bus.instr_latch_en = 1'b0;
  endtask

  int         bad;
  int         busy_low;
  int         acq_seen;
  logic [3:0] cnt_before;

  initial begin
    bus.instruction          = 8'h00;
    bus.trigger_channel_mask = 8'h00;
    bus.instr_latch_en       = 1'b0;
    repeat (2) @(negedge iclk);
    #1;
    check("rst_soft_rstn", bus.soft_rstn, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_force_trig", bus.force_trig, 0);
    check("rst_status", bus.status, 0);
    rstn = 1'b1;
    repeat (2) step();

    // START: pulse on the 4th edge after the fall, done one cycle later
    write_instr(8'h01, 8'h00);
    repeat (3) step();
    check("start_early", bus.acq_start, 0);
    step();
    check("start_pulse", bus.acq_start, 1);
    check("start_busy", bus.busy, 1);
    step();
    check("start_clear", bus.acq_start, 0);
    check("start_done", bus.instr_done, 1);
    step();
    check("start_done_clr", bus.instr_done, 0);
    check("start_idle", bus.busy, 0);

    // FORCE_TRIG with mask 0xA5 for 4 cycles
    write_instr(8'h04, 8'hA5);
    repeat (3) step();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.force_trig !== 8'hA5) bad++;
    end
    check("trig_width", bad, 0);
    step();
    check("trig_off", bus.force_trig, 8'h00);
    check("trig_done", bus.instr_done, 1);

    // CAL 0x12: three 8-high / 8-low periods
    repeat (2) step();
    write_instr(8'h12, 8'h00);
    repeat (3) step();
    bad = 0;
    busy_low = 0;
    for (int k = 0; k < 48; k++) begin
      step();
      if (bus.cal_pulse !== (((k / 8) % 2) == 0)) bad++;
      if (bus.busy !== 1'b1) busy_low++;
    end
    check("cal_shape", bad, 0);
    check("cal_busy", busy_low, 0);
    step();
    check("cal_done", bus.instr_done, 1);
    check("cal_idle_pulse", bus.cal_pulse, 0);

    // write during SOFT_RESET is dropped
    repeat (2) step();
    write_instr(8'h03, 8'h00);
    repeat (4) step();
    check("srst_low", bus.soft_rstn, 0);
    acq_seen = 0;
    write_instr(8'h01, 8'h00);
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.acq_start) acq_seen++;
    end
    check("busy_drop_acq", acq_seen, 0);
    check("err_busy_set", bus.err_busy, 1);
    check("srst_release", bus.soft_rstn, 1);
    check("srst_idle", bus.busy, 0);
    write_instr(8'h00, 8'h00);
    repeat (6) step();
    check("nop_clr_busy", bus.err_busy, 0);
    check("nop_clr_illegal", bus.err_illegal, 0);

    // illegal opcode
`ifdef INSTR_EXEC_STATUS_EN
    cnt_before = bus.status[3:0];
`else
    cnt_before = 4'd0;
`endif
    write_instr(8'h55, 8'h00);
    repeat (4) step();
    check("ill_flag", bus.err_illegal, 1);
    check("ill_done", bus.instr_done, 1);
    check("ill_ctrl", {bus.acq_start, bus.acq_stop, bus.soft_rstn, bus.cal_pulse, bus.force_trig}, 12'h200);
    step();
`ifdef INSTR_EXEC_STATUS_EN
    check("ill_exec_cnt", bus.status[3:0], cnt_before + 4'd1);
    check("ill_status_hi", bus.status[7:4], 4'b0100);
`else
    check("ill_status", bus.status, {4'h0, cnt_before});
`endif

    // async reset mid CAL burst
    write_instr(8'h1F, 8'h00);
    repeat (6) step();
    check("cal_run", bus.cal_pulse, 1);
    @(negedge iclk);
    rstn = 1'b0;
    #1;
    check("arst_cal", bus.cal_pulse, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_soft_rstn", bus.soft_rstn, 1);
    check("arst_err", bus.err_illegal, 0);
    @(negedge iclk);
    rstn = 1'b1;
    repeat (2) step();
    write_instr(8'h02, 8'h00);
    repeat (4) step();
    check("post_rst_stop", bus.acq_stop, 1);
    step();
    check("post_rst_done", bus.instr_done, 1);
    check("post_rst_stop_clr", bus.acq_stop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_exec.md
Name: instr_exec

Overview:
- Downstream consumer of the SPI instruction register (address 2) and trigger channel mask (address 1), running in the internal clock domain.
- Detects each completed SPI write to the instruction register, synchronises the write strobe from the sclk domain, and captures the instruction byte.
- Decodes the instruction and drives timed control pulses (acquisition start/stop, soft reset, forced trigger, calibration bursts) into the rest of the chip.
- Reports busy, completion and error status.

Parameters:
- RST_CYCLES, 16, width of the soft_rstn low pulse in iclk cycles (1..255).
- TRIG_WIDTH, 4, force_trig assertion length in iclk cycles (1..255).
- CAL_PERIOD, 8, iclk cycles per cal_pulse half-period (1..255).

Ports:
- iclk  in  1  internal clock; all flops rise on iclk.
- rstn  in  1  asynchronous active-low reset.
- instruction  in  8  instruction register contents; stable while instr_latch_en is low.
- instr_latch_en  in  1  latch enable of the instruction register (sclk domain, asynchronous to iclk).
- trigger_channel_mask  in  8  trigger channel mask register contents.
- acq_start  out  1  one-cycle start pulse.
- acq_stop  out  1  one-cycle stop pulse.
- soft_rstn  out  1  active-low soft reset for downstream logic.
- force_trig  out  8  per-channel forced trigger.
- cal_pulse  out  1  calibration pulse train.
- busy  out  1  an instruction is executing.
- instr_done  out  1  one-cycle completion pulse.
- err_illegal  out  1  sticky: an undefined opcode was received.
- err_busy  out  1  sticky: an instruction arrived while busy and was dropped.
- status  out  8  status byte (see Optional Feature).

Behaviour:
- Reset values: all outputs 0 except soft_rstn=1. State is IDLE, counters are 0, sync flops are 0.
- Synchroniser: instr_latch_en passes through 2 flops (s1, s2) plus a history flop s3. fall = s3 & ~s2.
- instr_latch_en must be high for at least 2 iclk periods. A shorter pulse may be missed; no detection is provided.
- On fall in IDLE:
  - capture instruction into op_q and trigger_channel_mask into mask_q;
  - next state is DECODE.
- On fall when not in IDLE: drop the write, set err_busy, leave the current execution undisturbed.
- Latency: first output action is registered on the 4th rising iclk edge after instr_latch_en falls.
- busy is 1 in every state other than IDLE.
- States:
  - IDLE: wait for fall.
  - DECODE (1 cycle): load the counter and select the action.
  - ACT: drive the action until the counter expires.
  - CAL_GAP: low half of the calibration period.
  - DONE: instr_done=1 for 1 cycle, then IDLE.
- Opcode actions:
  - 0x00 NOP: DECODE→DONE. Clears err_illegal and err_busy.
  - 0x01 START: ACT 1 cycle with acq_start=1.
  - 0x02 STOP: ACT 1 cycle with acq_stop=1.
  - 0x03 SOFT_RESET: ACT RST_CYCLES cycles with soft_rstn=0. Does not reset instr_exec itself.
  - 0x04 FORCE_TRIG: ACT TRIG_WIDTH cycles with force_trig=mask_q. If mask_q=0, the state sequence runs but force_trig stays 0.
  - 0x10..0x1F CAL: N = op[3:0]+1 pulses. Each pulse is ACT CAL_PERIOD cycles with cal_pulse=1, then CAL_GAP CAL_PERIOD cycles with cal_pulse=0. After the Nth gap, go to DONE.
  - All other opcodes: set err_illegal, DECODE→DONE, no other action.
- Counter: 8-bit down-counter. The action ends on the cycle the count reaches 1. The counter never wraps.
- Control outputs (acq_*, soft_rstn, force_trig, cal_pulse) are registered and glitch-free.
- rstn asserted mid-operation: outputs return to reset values immediately (asynchronously). Errors clear. A pending or in-flight instruction is discarded.
- A fall in the same cycle as DONE is treated as busy: the write is dropped and err_busy is set.

Optional Feature:
- Macro: INSTR_EXEC_STATUS_EN.
- Defined: status = {busy, err_illegal, err_busy, 1'b0, exec_cnt[3:0]}.
  - exec_cnt is a 4-bit count of completed instructions (DONE entries), including NOP and illegal opcodes.
  - exec_cnt wraps 15→0 and resets to 0.
- Undefined: status is tied to 8'h00 and exec_cnt is not built.

Test Plan:
- Write 0x01 (latch_en high for 3 iclk): acq_start=1 for exactly 1 cycle on the 4th iclk edge after the fall; instr_done 1 cycle later; busy=0 afterwards.
- Mask 0xA5, then write 0x04 with TRIG_WIDTH=4: force_trig=0xA5 for 4 cycles, then 0x00, then instr_done.
- Write 0x12 with CAL_PERIOD=8: 3 cal_pulse highs of 8 cycles separated by 8-cycle lows; busy is held throughout.
- Write 0x03, then write 0x01 during soft_rstn low: err_busy=1 and no acq_start. Then write 0x00: err_busy and err_illegal clear.
- Write 0x55: err_illegal=1, instr_done pulses, no control outputs move. With INSTR_EXEC_STATUS_EN defined, status[3:0] increments by 1.
- Assert rstn low mid-CAL burst: cal_pulse=0, busy=0, soft_rstn=1 immediately. After release, the next write executes normally.
